// File: rtl/spi_pixel_loader.sv
// SPI slave (mode 0, MSB first) that assembles GRB pixels into frame-buffer writes.
// Optional MISO status/echo path is built when SPI_LOADER_MISO_EN is defined.
module spi_pixel_loader #(
  parameter int unsigned NUM_LEDS = 160,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_ss,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [23:0]       pix_data,
  output logic              frame_commit,
  output logic              overflow
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddrHi, StAddrLo, StPixG, StPixR, StPixB, StIgnore
  } state_e;

  localparam logic [ADDR_W:0] NumLedsW  = (ADDR_W+1)'(NUM_LEDS);
  localparam logic [15:0]     NumLeds16 = 16'(NUM_LEDS);
  localparam logic [ADDR_W:0] AddrOne   = (ADDR_W+1)'(1);

  // Synchronizers and edge-detect history
  logic ss_meta_q, ss_sync_q, ss_prev_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  logic       sck_rise, ss_fall, byte_done;
  logic [7:0] rx_byte;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;

  state_e            state_q, state_d;
  logic [7:0]        addr_hi_q, addr_hi_d;
  logic [ADDR_W:0]   cur_addr_q, cur_addr_d;
  logic [7:0]        g_q, g_d, r_q, r_d;
  logic              pix_we_q, pix_we_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [23:0]       pix_data_q, pix_data_d;
  logic              frame_commit_q, frame_commit_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       full_addr;

  assign sck_rise  = sck_sync_q & ~sck_prev_q;
  assign ss_fall   = ss_prev_q & ~ss_sync_q;
  assign byte_done = sck_rise & (bit_cnt_q == 3'd7);
  assign rx_byte   = {shift_q, mosi_sync_q};
  assign full_addr = {addr_hi_q, rx_byte};

  // SS history resets low so a select already held low at reset release is not seen as a new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_meta_q   <= 1'b0;
      ss_sync_q   <= 1'b0;
      ss_prev_q   <= 1'b0;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
    end else begin
      ss_meta_q   <= spi_ss;
      ss_sync_q   <= ss_meta_q;
      ss_prev_q   <= ss_sync_q;
      sck_meta_q  <= spi_sck;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
      if (ss_sync_q) begin
        bit_cnt_q <= 3'd0;
      end else if (sck_rise) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (sck_rise) begin
        shift_q <= rx_byte[6:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      addr_hi_q      <= 8'd0;
      cur_addr_q     <= '0;
      g_q            <= 8'd0;
      r_q            <= 8'd0;
      pix_we_q       <= 1'b0;
      pix_addr_q     <= '0;
      pix_data_q     <= 24'd0;
      frame_commit_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_hi_q      <= addr_hi_d;
      cur_addr_q     <= cur_addr_d;
      g_q            <= g_d;
      r_q            <= r_d;
      pix_we_q       <= pix_we_d;
      pix_addr_q     <= pix_addr_d;
      pix_data_q     <= pix_data_d;
      frame_commit_q <= frame_commit_d;
      overflow_q     <= overflow_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_hi_d      = addr_hi_q;
    cur_addr_d     = cur_addr_q;
    g_d            = g_q;
    r_d            = r_q;
    pix_we_d       = 1'b0;
    pix_addr_d     = pix_addr_q;
    pix_data_d     = pix_data_q;
    frame_commit_d = 1'b0;
    overflow_d     = overflow_q;

    if (byte_done) begin
      case (state_q)
        StCmd: begin
          if (rx_byte == 8'h01) begin
            state_d = StAddrHi;
          end else if (rx_byte == 8'h02) begin
            frame_commit_d = 1'b1;
            overflow_d     = 1'b0;
            state_d        = StIgnore;
          end else begin
            state_d = StIgnore;
          end
        end
        StAddrHi: begin
          addr_hi_d = rx_byte;
          state_d   = StAddrLo;
        end
        StAddrLo: begin
          // Out-of-range start (including discarded high bits) parks at NUM_LEDS
          cur_addr_d = (full_addr >= NumLeds16) ? NumLedsW : full_addr[ADDR_W:0];
          state_d    = StPixG;
        end
        StPixG: begin
          g_d     = rx_byte;
          state_d = StPixR;
        end
        StPixR: begin
          r_d     = rx_byte;
          state_d = StPixB;
        end
        StPixB: begin
          if (cur_addr_q < NumLedsW) begin
            pix_we_d   = 1'b1;
            pix_addr_d = cur_addr_q[ADDR_W-1:0];
            pix_data_d = {g_q, r_q, rx_byte};
            cur_addr_d = cur_addr_q + AddrOne;
          end else begin
            overflow_d = 1'b1;
          end
          state_d = StPixG;
        end
        default: ;
      endcase
    end

    // A byte finishing together with deselect still takes effect above
    if (ss_sync_q) begin
      state_d = StIdle;
    end else if (state_q == StIdle && ss_fall) begin
      state_d = StCmd;
    end
  end

  assign pix_we       = pix_we_q;
  assign pix_addr     = pix_addr_q;
  assign pix_data     = pix_data_q;
  assign frame_commit = frame_commit_q;
  assign overflow     = overflow_q;

`ifdef SPI_LOADER_MISO_EN
  logic       sck_fall;
  logic [7:0] miso_sr_q;
  logic       miso_en_q;
  logic       miso_skip_q;

  assign sck_fall = sck_prev_q & ~sck_sync_q;

  // The falling edge right after a reload must not shift, or the echo MSB is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_sr_q   <= 8'd0;
      miso_en_q   <= 1'b0;
      miso_skip_q <= 1'b0;
    end else if (ss_sync_q) begin
      miso_en_q   <= 1'b0;
      miso_skip_q <= 1'b0;
    end else if (ss_fall) begin
      miso_en_q   <= 1'b1;
      miso_sr_q   <= {7'd0, overflow_q};
      miso_skip_q <= 1'b0;
    end else if (byte_done) begin
      miso_sr_q   <= rx_byte;
      miso_skip_q <= 1'b1;
    end else if (sck_fall) begin
      if (miso_skip_q) begin
        miso_skip_q <= 1'b0;
      end else begin
        miso_sr_q <= {miso_sr_q[6:0], 1'b0};
      end
    end
  end

  assign spi_miso = miso_en_q ? miso_sr_q[7] : 1'bz;
`else
  assign spi_miso = 1'bz;
`endif

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Scoreboard bench for spi_pixel_loader: expected writes/commits are queued, a monitor checks them.
module tb_spi_pixel_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_ss;
  logic        spi_sck;
  logic        spi_mosi;
  wire         spi_miso;
  logic        pix_we;
  logic [7:0]  pix_addr;
  logic [23:0] pix_data;
  logic        frame_commit;
  logic        overflow;

  spi_pixel_loader #(
    .NUM_LEDS(160),
    .ADDR_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_ss      (spi_ss),
    .spi_sck     (spi_sck),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .pix_we      (pix_we),
    .pix_addr    (pix_addr),
    .pix_data    (pix_data),
    .frame_commit(frame_commit),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [23:0] data;
  } wr_t;

  int         total = 0;
  int         bad = 0;
  wr_t        exp_wr[$];
  int         exp_commits = 0;
  wr_t        got;
  logic [7:0] tx_q[$];
  logic [7:0] miso_rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe and commit pulse must match a queued expectation
  always @(negedge clk) begin
    if (pix_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", pix_addr,
                 pix_data);
      end else begin
        got = exp_wr.pop_front();
        check("wr_addr", 32'(pix_addr), 32'(got.addr));
        check("wr_data", 32'(pix_data), 32'(got.data));
      end
    end
    if (frame_commit === 1'b1) begin
      check("commit_expected", 32'(exp_commits > 0), 32'd1);
      if (exp_commits > 0) exp_commits--;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic [7:0] rx;
    rx = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      clks(5);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      clks(5);
      spi_sck = 1'b0;
    end
    if (n == 8) miso_rx.push_back(rx);
  endtask

  task automatic run_txn();
    miso_rx.delete();
    spi_ss = 1'b0;
    clks(6);
    foreach (tx_q[i]) send_bits(tx_q[i], 8);
    clks(6);
    spi_ss = 1'b1;
    clks(8);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    spi_ss   = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    clks(4);
    rst = 1'b0;
    clks(4);
    check("rst_pix_we", 32'(pix_we), 32'd0);
    check("rst_pix_addr", 32'(pix_addr), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_commit", 32'(frame_commit), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single pixel
    exp_wr.push_back('{8'd5, 24'h112233});
    tx_q = '{8'h01, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33};
    run_txn();
    check("single_overflow", 32'(overflow), 32'd0);
    check("hold_addr", 32'(pix_addr), 32'd5);
    check("hold_data", 32'(pix_data), 32'h112233);

    // Burst up to the last LED
    exp_wr.push_back('{8'd158, 24'hAABBCC});
    exp_wr.push_back('{8'd159, 24'hDDEEFF});
    tx_q = '{8'h01, 8'h00, 8'h9E, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_txn();
    check("burst_overflow", 32'(overflow), 32'd0);

    // Run past the end: one write then saturation
    exp_wr.push_back('{8'd159, 24'h111111});
    tx_q = '{8'h01, 8'h00, 8'h9F, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22,
             8'h33, 8'h33, 8'h33};
    run_txn();
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_hold_addr", 32'(pix_addr), 32'd159);

`ifdef SPI_LOADER_MISO_EN
    tx_q = '{8'h5A, 8'hC3};
    run_txn();
    check("miso_status", 32'(miso_rx[0]), 32'h01);
    check("miso_echo", 32'(miso_rx[1]), 32'h5A);
`endif

    // Commit clears overflow
    exp_commits++;
    tx_q = '{8'h02};
    run_txn();
    check("commit_ovf_clear", 32'(overflow), 32'd0);

    // Partial pixel, then partial byte, both discarded
    tx_q = '{8'h01, 8'h00, 8'h05, 8'h11, 8'h22};
    run_txn();
    spi_ss = 1'b0;
    clks(6);
    send_bits(8'h01, 3);
    clks(6);
    spi_ss = 1'b1;
    clks(8);
    exp_wr.push_back('{8'd7, 24'h010203});
    tx_q = '{8'h01, 8'h00, 8'h07, 8'h01, 8'h02, 8'h03};
    run_txn();

    // Unknown command ignores following bytes
    tx_q = '{8'h7E, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    run_txn();

    // Nonzero high address byte is out of range
    tx_q = '{8'h01, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    run_txn();
    check("hi_byte_ovf", 32'(overflow), 32'd1);
    check("hi_byte_hold_addr", 32'(pix_addr), 32'd7);

    // Reset in the middle of a byte
    spi_ss = 1'b0;
    clks(6);
    send_bits(8'h01, 8);
    send_bits(8'h00, 8);
    send_bits(8'h55, 4);
    rst = 1'b1;
    clks(1);
    check("midrst_pix_we", 32'(pix_we), 32'd0);
    check("midrst_pix_addr", 32'(pix_addr), 32'd0);
    check("midrst_pix_data", 32'(pix_data), 32'd0);
    check("midrst_commit", 32'(frame_commit), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    clks(2);
    rst    = 1'b0;
    spi_ss = 1'b1;
    clks(8);

    exp_wr.push_back('{8'd0, 24'h0A0B0C});
    tx_q = '{8'h01, 8'h00, 8'h00, 8'h0A, 8'h0B, 8'h0C};
    run_txn();

    clks(20);
    check("pending_writes", 32'(exp_wr.size()), 32'd0);
    check("pending_commits", 32'(exp_commits), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
